// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, LOCK, RELEASE} arb_state_e;

  localparam int N_REQ_DEF   = 2;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 4096;

  // Widths never collapse below one bit, even for degenerate parameters.
  function automatic int ptr_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after the pointer, with wrap.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] winner_o
);

  logic found;

  // Offset i walks the ring from pointer+1; j keeps the bit index constant.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && req_i[j] && (((int'(ptr_i) + i) % N_REQ) == j)) begin
          winner_o[j] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX FIFO write port among requesters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    tx_full,
  output logic                    wr_uart,
  output logic [DATA_W-1:0]       w_data,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int               PTR_W   = ptr_width(N_REQ);
  localparam int               CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d, pick;
  logic [PTR_W-1:0]  ptr_q, ptr_d, grant_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d, terr_q, terr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, sel_data;
  logic              sel_last, xfer;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .winner_o (pick)
  );

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant_q[j]) begin
        sel_data  = req_data[j*DATA_W +: DATA_W];
        sel_last  = req_last[j];
        grant_idx = PTR_W'(j);
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      terr_q  <= terr_d;
    end
  end

  // An accepted byte outranks an expiring idle count, so a last byte never raises timeout_err.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req_valid) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          wr_d    = 1'b1;
          wdata_d = sel_data;
          cnt_d   = '0;
          if (sel_last) state_d = RELEASE;
        end else if (!tx_full) begin
          if (cnt_q == CNT_MAX) begin
            state_d = RELEASE;
            terr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RELEASE: begin
        grant_d = '0;
        ptr_d   = grant_idx;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding off during the write strobe keeps tx_full current for the next accept.
  always_comb begin
    req_ready = '0;
    if (state_q == LOCK && !tx_full && !wr_q) req_ready = grant_q;
    busy = (state_q != IDLE);
  end

  assign wr_uart     = wr_q;
  assign w_data      = wdata_q;
  assign grant       = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle handshake scoreboard plus directed scenarios.
module tb_uart_tx_arbiter;

   localparam int N_REQ   = 2;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_last, req_ready, grant;
   logic [15:0] req_data;
   logic        tx_full, wr_uart, busy, timeout_err;
   logic [7:0]  w_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Requester sources: bit 8 is the last flag, bits 7:0 the byte.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [1:0] en = 2'b11;

   logic [1:0] fireSeen = 2'b00;
   logic       pendValid = 1'b0;
   logic [7:0] pendByte = 8'h00;
   int         toCount = 0;
   int         toCyc = 0;

   logic [7:0] wrLog[$];
   int         cycLog[$];
   logic [1:0] grLog[$];
   logic [7:0] expB[$];
   int         expC[$];
   logic [1:0] expG[$];

   int base;
   int toBefore;

   uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_full     (tx_full),
      .wr_uart     (wr_uart),
      .w_data      (w_data),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present the head of each source queue, or nothing when empty or held back.
   task automatic driveInputs();
      req_valid = 2'b00;
      req_last  = 2'b00;
      req_data  = '0;
      if (q0.size() > 0 && en[0]) begin
         req_valid[0]   = 1'b1;
         req_data[7:0]  = q0[0][7:0];
         req_last[0]    = q0[0][8];
      end
      if (q1.size() > 0 && en[1]) begin
         req_valid[1]   = 1'b1;
         req_data[15:8] = q1[0][7:0];
         req_last[1]    = q1[0][8];
      end
   endtask

   // Advance n cycles; bytes accepted in the previous cycle leave their source queue.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (fireSeen[0] && q0.size() > 0) void'(q0.pop_front());
         if (fireSeen[1] && q1.size() > 0) void'(q1.pop_front());
         driveInputs();
      end
   endtask

   task automatic checkLogs(input string name, input int b);
      checkOutput({name, "_count"}, wrLog.size(), expB.size());
      for (int k = 0; k < expB.size(); k++) begin
         if (k < wrLog.size()) begin
            checkOutput({name, "_byte"}, wrLog[k], expB[k]);
            checkOutput({name, "_cycle"}, cycLog[k] - b, expC[k]);
            checkOutput({name, "_grant"}, grLog[k], expG[k]);
         end
      end
      wrLog.delete(); cycLog.delete(); grLog.delete();
      expB.delete(); expC.delete(); expG.delete();
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_grant"}, grant, 0);
      checkOutput({name, "_wr"}, wr_uart, 0);
      checkOutput({name, "_wdata"}, w_data, 0);
      checkOutput({name, "_busy"}, busy, 0);
      checkOutput({name, "_timeout"}, timeout_err, 0);
      checkOutput({name, "_ready"}, req_ready, 0);
   endtask

   // Every accepted byte must appear on w_data exactly one cycle later; only the owner is
   // ever ready, never while the FIFO is full or a strobe is out.
   always @(negedge clk) begin
      logic [1:0] fired;
      if (reset) begin
         pendValid <= 1'b0;
         fireSeen  <= 2'b00;
      end else begin
         checkOutput("wr_uart_timing", wr_uart, pendValid);
         if (wr_uart && pendValid) checkOutput("w_data", w_data, pendByte);
         checkOutput("ready_not_owner", |(req_ready & ~grant), 0);
         checkOutput("ready_when_stalled", (|req_ready) & (tx_full | wr_uart), 0);
         checkOutput("grant_onehot", $onehot0(grant), 1);
         checkOutput("busy_with_grant", (|grant) & ~busy, 0);
         if (wr_uart) begin
            wrLog.push_back(w_data);
            cycLog.push_back(cyc);
            grLog.push_back(grant);
         end
         if (timeout_err) begin
            toCount <= toCount + 1;
            toCyc   <= cyc;
         end
         fired = req_valid & req_ready;
         fireSeen  <= fired;
         pendValid <= |fired;
         pendByte  <= fired[1] ? req_data[15:8] : req_data[7:0];
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      tx_full = 1'b0;
      driveInputs();
      #1;
      checkAllZero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Single requester, single-byte packet.
      q0.push_back({1'b1, 8'h41});
      driveInputs();
      @(negedge clk);
      checkOutput("single_idle_grant", grant, 2'b00);
      applyStimulus(1);
      @(negedge clk);
      checkOutput("single_grant", grant, 2'b01);
      checkOutput("single_ready", req_ready, 2'b01);
      applyStimulus(1);
      @(negedge clk);
      checkOutput("single_wr", wr_uart, 1);
      checkOutput("single_wdata", w_data, 8'h41);
      checkOutput("single_busy_release", busy, 1);
      applyStimulus(1);
      @(negedge clk);
      checkOutput("single_busy_idle", busy, 0);
      checkOutput("single_grant_idle", grant, 2'b00);
      wrLog.delete(); cycLog.delete(); grLog.delete();

      // Contention straight after reset: requester 0 wins first.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      q0.push_back({1'b1, 8'h41});
      q1.push_back({1'b1, 8'h42});
      driveInputs();
      base = cyc;
      applyStimulus(10);
      expB = '{8'h41, 8'h42}; expC = '{2, 5}; expG = '{2'b01, 2'b10};
      checkLogs("contention", base);

      // Packet lock with round-robin hand-off between packets.
      q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42});
      q0.push_back({1'b1, 8'h43}); q0.push_back({1'b1, 8'h44});
      q1.push_back({1'b1, 8'h5A}); q1.push_back({1'b1, 8'h5B});
      driveInputs();
      base = cyc;
      applyStimulus(20);
      expB = '{8'h41, 8'h42, 8'h43, 8'h5A, 8'h44, 8'h5B};
      expC = '{2, 4, 6, 9, 12, 15};
      expG = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
      checkLogs("lock", base);

      // Backpressure for 50 cycles must not count towards the timeout.
      toBefore = toCount;
      tx_full = 1'b1;
      q0.push_back({1'b1, 8'h61});
      driveInputs();
      base = cyc;
      applyStimulus(49);
      @(negedge clk);
      checkOutput("bp_grant", grant, 2'b01);
      checkOutput("bp_ready", req_ready, 2'b00);
      checkOutput("bp_busy", busy, 1);
      applyStimulus(1);
      checkOutput("bp_no_write", wrLog.size(), 0);
      checkOutput("bp_no_timeout", toCount, toBefore);
      tx_full = 1'b0;
      driveInputs();
      applyStimulus(4);
      expB = '{8'h61}; expC = '{51}; expG = '{2'b01};
      checkLogs("bp", base);

      // Timeout: req0 goes quiet mid-packet, req1 waits and is served after the forced release.
      toBefore = toCount;
      q0.push_back({1'b0, 8'h41});
      driveInputs();
      base = cyc;
      applyStimulus(3);
      q1.push_back({1'b1, 8'h5A});
      driveInputs();
      applyStimulus(22);
      checkOutput("to_pulses", toCount - toBefore, 1);
      checkOutput("to_cycle", toCyc - base, 18);
      expB = '{8'h41, 8'h5A}; expC = '{2, 21}; expG = '{2'b01, 2'b10};
      checkLogs("timeout", base);

      // Last byte accepted exactly as the idle count expires: no timeout.
      toBefore = toCount;
      q0.push_back({1'b0, 8'h70}); q0.push_back({1'b1, 8'h71});
      driveInputs();
      base = cyc;
      applyStimulus(1);
      @(negedge clk);
      en[0] = 1'b0;
      applyStimulus(1);
      applyStimulus(14);
      en[0] = 1'b1;
      applyStimulus(1);
      @(negedge clk);
      checkOutput("lastwin_ready", req_ready, 2'b01);
      applyStimulus(4);
      checkOutput("lastwin_no_timeout", toCount, toBefore);
      expB = '{8'h70, 8'h71}; expC = '{2, 18}; expG = '{2'b01, 2'b01};
      checkLogs("lastwin", base);

      // Reset in the middle of a req1 packet, then a fresh contention.
      q1.push_back({1'b0, 8'h81}); q1.push_back({1'b0, 8'h82}); q1.push_back({1'b1, 8'h83});
      driveInputs();
      applyStimulus(2);
      #2 reset = 1'b1;
      #1;
      checkAllZero("midreset");
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("midreset_no_log", wrLog.size(), 0);
      wrLog.delete(); cycLog.delete(); grLog.delete();
      q0.push_back({1'b1, 8'h91});
      driveInputs();
      base = cyc;
      applyStimulus(12);
      expB = '{8'h91, 8'h82, 8'h83}; expC = '{2, 5, 7}; expG = '{2'b01, 2'b10, 2'b10};
      checkLogs("postreset", base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
